parity_packet_serializer: RTL

Downstream neighbour of the per-row XOR tree. Each cycle the XOR tree produces one parity row's result: W packets of PACKET_LENGTH bits, bit-sliced. This block captures that result with a valid/ready handshake into a two-slot ping-pong buffer. It then streams the result out as PACKET_LENGTH beats of one W-bit word each, transposing packet-major data into word-major output for the write-back path.

---
 rtl/parity_packet_serializer_pkg.sv | 31 +++
 rtl/parity_packet_serializer_if.sv | 41 ++++
 rtl/parity_packet_serializer_transpose.sv | 29 ++
 rtl/parity_packet_serializer.sv | 104 ++++++++++
 4 files changed

// File: rtl/parity_packet_serializer_pkg.sv
// Shared serializer engine types and width helpers.
// Used by the parity write-back serializers.
package parity_packet_serializer_pkg;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } cnt_e;

  localparam int W_DEF  = 4;
  localparam int PL_DEF = 2;
  localparam int M_DEF  = 128;

  function automatic int row_w(int m_max);
    return (m_max > 1) ? $clog2(m_max) : 1;
  endfunction

  function automatic int beat_w(int plen);
    return (plen > 1) ? $clog2(plen) : 1;
  endfunction

  // Slot layout at the default geometry.
  typedef struct packed {
    logic [0:W_DEF-1][PL_DEF-1:0] pkt;
    logic [row_w(M_DEF)-1:0]      row;
    logic                         last_row;
    logic                         full;
  } slot_t;

endpackage

// File: rtl/parity_packet_serializer_if.sv
// Row-in / beat-out handshake bundle of the
// parity packet serializer.
interface parity_packet_serializer_if
  import parity_packet_serializer_pkg::*;
#(
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2,
  parameter int ROW_W         = 7,
  parameter int BW            = 1
);

  logic                               in_valid;
  logic                               in_ready;
  logic [ROW_W-1:0]                   in_row;
  logic                               in_last_row;
  logic [0:W-1][PACKET_LENGTH-1:0]    xor_product;
  logic                               out_valid;
  logic                               out_ready;
  logic [W-1:0]                       out_word;
  logic [ROW_W-1:0]                   out_row;
  logic [BW-1:0]                      out_beat;
  logic                               out_last;
  logic                               out_last_row;

  modport master (
    output in_valid, in_row, in_last_row,
    output xor_product, out_ready,
    input  in_ready, out_valid, out_word,
    input  out_row, out_beat, out_last,
    input  out_last_row
  );

  modport slave (
    input  in_valid, in_row, in_last_row,
    input  xor_product, out_ready,
    output in_ready, out_valid, out_word,
    output out_row, out_beat, out_last,
    output out_last_row
  );

endinterface

// File: rtl/parity_packet_serializer_transpose.sv
// Picks one bit column out of W packets to
// form a W-bit beat word.
module packet_word_transpose #(
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2,
  parameter int BW            = 1
) (
  input  logic [0:W-1][PACKET_LENGTH-1:0] pkt,
  input  logic [BW-1:0]                   beat,
  output logic [W-1:0]                    word
);

  if (PACKET_LENGTH == 1) begin : g_single
    logic unused_beat;
    assign unused_beat = ^beat;
    always_comb begin
      word = '0;
      for (int i = 0; i < W; i++)
        word[i] = pkt[i][0];
    end
  end else begin : g_multi
    always_comb begin
      word = '0;
      for (int i = 0; i < W; i++)
        word[i] = pkt[i][beat];
    end
  end

endmodule

// File: rtl/parity_packet_serializer.sv
// Ping-pong buffered serializer: one parity row
// in, PACKET_LENGTH word-major beats out.
module parity_packet_serializer
  import parity_packet_serializer_pkg::*;
#(
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2,
  parameter int M_MAX         = 128
) (
  input logic                       clk,
  input logic                       rst,
  parity_packet_serializer_if.slave bus
);

  localparam int ROW_W = row_w(M_MAX);
  localparam int BW    = beat_w(PACKET_LENGTH);

  typedef struct packed {
    logic [0:W-1][PACKET_LENGTH-1:0] pkt;
    logic [ROW_W-1:0]                row;
    logic                            last_row;
    logic                            full;
  } slot_q_t;

  slot_q_t     slot [2];
  slot_q_t     cur;
  cnt_e        cnt_q, cnt_d;
  logic        wr_ptr, rd_ptr;
  logic [BW-1:0] beat_cnt;
  logic        accept, pop, last_beat, done;
  logic [W-1:0] word;

  assign cur       = slot[rd_ptr];
  assign accept    = bus.in_valid && bus.in_ready;
  assign pop       = cur.full && bus.out_ready;
  assign last_beat = (beat_cnt == BW'(PACKET_LENGTH-1));
  assign done      = pop && last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= CNT_EMPTY;
    else
      cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      accept && !done:
        cnt_d = (cnt_q == CNT_EMPTY) ? CNT_ONE
                                     : CNT_FULL;
      done && !accept:
        cnt_d = (cnt_q == CNT_FULL) ? CNT_ONE
                                    : CNT_EMPTY;
      default: cnt_d = cnt_q;
    endcase
  end

  // Accept and final pop always hit different slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++)
        slot[i] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      if (accept) begin
        slot[wr_ptr] <= {bus.xor_product, bus.in_row,
                         bus.in_last_row, 1'b1};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        if (last_beat) begin
          beat_cnt          <= '0;
          slot[rd_ptr].full <= 1'b0;
          rd_ptr            <= ~rd_ptr;
        end else begin
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
    end
  end

  packet_word_transpose #(
    .W             (W),
    .PACKET_LENGTH (PACKET_LENGTH),
    .BW            (BW)
  ) u_transpose (
    .pkt  (cur.pkt),
    .beat (beat_cnt),
    .word (word)
  );

  assign bus.in_ready     = (cnt_q != CNT_FULL);
  assign bus.out_valid    = cur.full;
  assign bus.out_word     = cur.full ? word : '0;
  assign bus.out_row      = cur.full ? cur.row : '0;
  assign bus.out_beat     = cur.full ? beat_cnt : '0;
  assign bus.out_last     = cur.full && last_beat;
  assign bus.out_last_row = cur.full && last_beat &&
                            cur.last_row;

endmodule
